// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: owns the PC, drives the imem request/ready
// handshake and presents the registered IF/ID bundle to decode.
module fetch_stage #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imemRead,
   output logic [31:0] imemAddr,
   input  logic        imemReady,
   input  logic [31:0] imemData,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirectTarget,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   output logic [31:0] pcPlus4,
   output logic        valid
);

   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      DISCARD
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_reg_q, pc_reg_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] pending_q, pending_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic        valid_q, valid_d;
   logic [31:0] target;

   assign target = redirectTarget & ~32'd3;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= FETCH;
         pc_reg_q   <= RESET_VECTOR;
         hold_q     <= '0;
         pending_q  <= '0;
         instr_q    <= NOP_INSTR;
         pc_q       <= '0;
         pc_plus4_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_reg_q   <= pc_reg_d;
         hold_q     <= hold_d;
         pending_q  <= pending_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_reg_d   = pc_reg_q;
      hold_d     = hold_q;
      pending_d  = pending_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      imemRead   = 1'b0;
      imemAddr   = '0;

      unique case (state_q)
         FETCH: begin
            imemRead = 1'b1;
            imemAddr = pc_reg_q & ~32'd3;
            if (redirect) begin
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               if (imemReady) begin
                  pc_reg_d = target;
               end else begin
                  pending_d = target;
                  state_d   = DISCARD;
               end
            end else if (imemReady && !stall) begin
               instr_d    = imemData;
               pc_d       = pc_reg_q;
               pc_plus4_d = pc_reg_q + 32'd4;
               valid_d    = 1'b1;
               pc_reg_d   = pc_reg_q + 32'd4;
            end else if (imemReady) begin
               // Decode is stalled: park the word so the request can retire.
               hold_d  = imemData;
               state_d = HOLD;
            end else if (!stall) begin
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
            end
         end
         HOLD: begin
            if (redirect) begin
               valid_d  = 1'b0;
               instr_d  = NOP_INSTR;
               pc_reg_d = target;
               state_d  = FETCH;
            end else if (!stall) begin
               instr_d    = hold_q;
               pc_d       = pc_reg_q;
               pc_plus4_d = pc_reg_q + 32'd4;
               valid_d    = 1'b1;
               pc_reg_d   = pc_reg_q + 32'd4;
               state_d    = FETCH;
            end
         end
         DISCARD: begin
            // Wait out the stale response before issuing the redirected fetch.
            imemRead = 1'b1;
            imemAddr = pc_reg_q & ~32'd3;
            valid_d  = 1'b0;
            instr_d  = NOP_INSTR;
            if (redirect) pending_d = target;
            if (imemReady) begin
               pc_reg_d = redirect ? target : pending_q;
               state_d  = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase

      if (reset) imemRead = 1'b0;
   end

   assign instruction = instr_q;
   assign pc          = pc_q;
   assign pcPlus4     = pc_plus4_q;
   assign valid       = valid_q;

endmodule
